l2_mem_responder: RTL and testbench

- Memory-side responder for the generic bus; the far end of the L2 cache's downstream (cpu-modport) port.
- Accepts single-word read/write requests, applies a configurable fixed access latency and completes each request with a one-cycle busy-low handshake.
- Backed by a word-addressed on-chip array with byte-enabled writes.
- Used as the main-memory model under the L2 in simulation and FPGA builds.

---
 rtl/mem_resp_pkg.sv | 16 +
 rtl/generic_bus_if.sv | 22 ++
 rtl/mem_resp_sram.sv | 30 +++
 rtl/l2_mem_responder.sv | 133 +++++++++++++
 tb/tb_l2_mem_responder.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the L2 memory-side responder.
package mem_resp_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } resp_state_t;

  localparam word_t       BAD_READ_DATA = 32'hBAD1_BAD1;
  // Wide enough for the largest legal LATENCY of 15.
  localparam int unsigned CNT_W         = 4;

endpackage

// File: rtl/generic_bus_if.sv
// Single-word generic bus between the L2 downstream port and its memory responder.
interface generic_bus_if;
  import mem_resp_pkg::*;

  word_t       addr;
  word_t       wdata;
  word_t       rdata;
  logic        ren;
  logic        wen;
  logic [3:0]  byte_en;
  logic        busy;

  modport generic_bus (
    input  addr, wdata, ren, wen, byte_en,
    output rdata, busy
  );

  modport cpu (
    output addr, wdata, ren, wen, byte_en,
    input  rdata, busy
  );
endinterface

// File: rtl/mem_resp_sram.sv
// DEPTH x 32 backing array: synchronous byte-enabled write, combinational read.
// Kept separate so it can be swapped for a vendor BRAM macro.
module mem_resp_sram
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  word_t                    i_wdata,
  input  logic [3:0]               i_be,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output word_t                    o_rdata
);

  word_t r_mem [DEPTH];

  // NOTE: the array has no reset; clearing it would forbid BRAM mapping and contents survive reset anyway.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/l2_mem_responder.sv
// Main-memory model on the L2 downstream generic bus: fixed-latency single-word responder.
// Optional page-mode sequential fast path enabled by defining L2_MEM_RESP_SEQ_FAST_EN.
module l2_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  generic_bus_if.generic_bus         mem_gen_bus_if
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  resp_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  word_t            r_req_addr;
  logic             r_req_wr;
  word_t            r_rdata;

  logic             w_req;
  logic             w_abort;
  logic             w_fast;
  logic             w_we;
  word_t            w_sram_rdata;
  word_t            w_rd_word;

  // Anything below BASE_ADDR wraps to a huge 33-bit offset and fails the span test.
  function automatic logic in_range(word_t a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return off < SPAN;
  endfunction

  function automatic logic [AW-1:0] to_index(word_t a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  assign w_req     = mem_gen_bus_if.ren | mem_gen_bus_if.wen;
  assign w_abort   = !w_req
                   || (mem_gen_bus_if.addr != r_req_addr)
                   || (mem_gen_bus_if.wen  != r_req_wr);
  assign w_we      = (r_state == DONE) && r_req_wr && in_range(r_req_addr);
  assign w_rd_word = in_range(mem_gen_bus_if.addr) ? w_sram_rdata : BAD_READ_DATA;

  mem_resp_sram #(.DEPTH(DEPTH)) u_sram (
    .i_clk   (CLK),
    .i_we    (w_we),
    .i_waddr (to_index(r_req_addr)),
    .i_wdata (mem_gen_bus_if.wdata),
    .i_be    (mem_gen_bus_if.byte_en),
    .i_raddr (to_index(mem_gen_bus_if.addr)),
    .o_rdata (w_sram_rdata)
  );

`ifdef L2_MEM_RESP_SEQ_FAST_EN
  word_t r_last_addr;
  logic  r_last_wr;
  logic  r_last_vld;

  assign w_fast = r_last_vld
               && (mem_gen_bus_if.addr == r_last_addr + 32'd4)
               && (mem_gen_bus_if.wen  == r_last_wr);

  // An idle IDLE cycle or an abort breaks the burst.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_last_vld  <= 1'b0;
      r_last_addr <= '0;
      r_last_wr   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (!w_req) r_last_vld <= 1'b0;
        WAIT: if (w_abort) r_last_vld <= 1'b0;
        DONE: begin
          r_last_vld  <= 1'b1;
          r_last_addr <= r_req_addr;
          r_last_wr   <= r_req_wr;
        end
        default: r_last_vld <= 1'b0;
      endcase
    end
  end
`else
  assign w_fast = 1'b0;
`endif

  // NOTE: state is updated only with non-blocking assignments so every read in this block sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rdata    <= '0;
      r_req_addr <= '0;
      r_req_wr   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_req_addr <= mem_gen_bus_if.addr;
            r_req_wr   <= mem_gen_bus_if.wen;
            if (LATENCY == 1 || w_fast) begin
              if (!mem_gen_bus_if.wen) r_rdata <= w_rd_word;
              r_state <= DONE;
            end else begin
              r_cnt   <= CNT_W'(LATENCY - 1);
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (w_abort) begin
            r_state <= IDLE;
          end else if (r_cnt == CNT_W'(1)) begin
            if (!r_req_wr) r_rdata <= w_rd_word;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_gen_bus_if.busy  = (r_state != DONE);
  assign mem_gen_bus_if.rdata = r_rdata;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Self-checking bench for l2_mem_responder against a word-array reference model.
module tb_l2_mem_responder;
  import mem_resp_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int unsigned LAT   = 4;
`ifdef L2_MEM_RESP_SEQ_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  generic_bus_if bus();

  l2_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .CLK            (clk),
    .RST            (rst),
    .mem_gen_bus_if (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    checks = 0;
  int    errors = 0;

  // Reference model state
  word_t       model_mem [DEPTH];
  word_t       exp_rdata;
  bit          last_vld;
  word_t       last_addr;
  bit          last_wr;
  int unsigned done_cyc;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(word_t a);
    return (a >= BASE) && ((a - BASE) < 32'(DEPTH * 4));
  endfunction

  function automatic int unsigned idx(word_t a);
    return int'((a - BASE) >> 2) % DEPTH;
  endfunction

  function automatic word_t waddr(int unsigned w);
    return BASE + 32'(w * 4);
  endfunction

  // Called at posedge+1; leaves the bus idle for n cycles.
  task automatic idle(int n);
    bus.ren = 1'b0;
    bus.wen = 1'b0;
    if (n > 0) last_vld = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a request at posedge+1, waits for completion and checks latency and rdata.
  // Returns at posedge+1 of the cycle after completion with the bus idle.
  task automatic do_req(string tag, word_t a, bit rd, bit wr, word_t wd, logic [3:0] be,
                        int extra = 0);
    int lat;
    int exp_lat;
    bus.addr    = a;
    bus.wdata   = wd;
    bus.byte_en = be;
    bus.ren     = rd;
    bus.wen     = wr;
    exp_lat = ((FAST && last_vld && a == last_addr + 32'd4 && wr == last_wr) ? 1 : LAT) + extra;
    if (wr) begin
      if (in_rng(a)) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model_mem[idx(a)][8*b +: 8] = wd[8*b +: 8];
      end
    end else begin
      exp_rdata = in_rng(a) ? model_mem[idx(a)] : BAD_READ_DATA;
    end
    @(negedge clk);
    lat = 0;
    while (bus.busy !== 1'b0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    done_cyc = cyc;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " rdata"}, bus.rdata, exp_rdata);
    last_vld  = 1'b1;
    last_addr = a;
    last_wr   = wr;
    @(posedge clk);
    #1;
    bus.ren = 1'b0;
    bus.wen = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned start;
    int unsigned offs [4];
    word_t       a;
    word_t       prev_a;

    rst         = 1'b1;
    bus.addr    = '0;
    bus.wdata   = '0;
    bus.byte_en = '0;
    bus.ren     = 1'b0;
    bus.wen     = 1'b0;
    last_vld    = 1'b0;
    last_addr   = '0;
    last_wr     = 1'b0;
    exp_rdata   = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", bus.busy, 1'b1);
    check("reset rdata", bus.rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post-reset busy", bus.busy, 1'b1);
    @(posedge clk); #1;
    idle(1);

    // Preload words 0..31 with a back-to-back sequential write burst
    for (int w = 0; w < 32; w++) begin
      word_t v;
      v = (w == 5) ? 32'hDEAD_BEEF : (w == 2) ? 32'h1122_3344 : (w == 3) ? 32'h0 : $urandom;
      do_req("preload", waddr(w), 1'b0, 1'b1, v, 4'hF);
    end
    idle(2);

    // Single read of word 5, with busy returning high right after
    do_req("read w5", waddr(5), 1'b1, 1'b0, '0, 4'h0);
    check("read w5 value", bus.rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("busy after done", bus.busy, 1'b1);
    @(posedge clk); #1;
    idle(1);

    // Byte-enabled write then read back
    do_req("bytewr w2", waddr(2), 1'b0, 1'b1, 32'hAABB_CCDD, 4'b0101);
    idle(1);
    do_req("read w2", waddr(2) + 32'd3, 1'b1, 1'b0, '0, 4'hF);
    check("bytewr w2 merged", bus.rdata, 32'h11BB_33DD);
    idle(1);

    // Abort by dropping ren in cycle 2, re-issue in cycle 3
    bus.addr = waddr(7); bus.ren = 1'b1; bus.wen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("abort busy pre", bus.busy, 1'b1);
      @(posedge clk); #1;
    end
    bus.ren = 1'b0;
    @(negedge clk);
    check("abort busy c2", bus.busy, 1'b1);
    @(posedge clk); #1;
    last_vld = 1'b0;
    do_req("after abort", waddr(7), 1'b1, 1'b0, '0, 4'h0);
    idle(1);

    // Abort by address change in WAIT: re-accepted one cycle later
    bus.addr = waddr(8); bus.ren = 1'b1; bus.wen = 1'b0;
    @(posedge clk); #1;
    last_vld = 1'b0;
    do_req("addr change", waddr(9), 1'b1, 1'b0, '0, 4'h0, 1);
    idle(1);

    // Out of range above and below the window
    do_req("oor read", BASE + 32'(DEPTH * 4), 1'b1, 1'b0, '0, 4'h0);
    check("oor read value", bus.rdata, BAD_READ_DATA);
    idle(1);
    do_req("oor write", BASE + 32'(DEPTH * 4), 1'b0, 1'b1, 32'h1, 4'hF);
    idle(1);
    do_req("read w0", waddr(0), 1'b1, 1'b0, '0, 4'h0);
    idle(1);
    do_req("below base", BASE - 32'd4, 1'b1, 1'b0, '0, 4'h0);
    idle(1);

    // Reset one cycle before a write would complete
    do_req("pre-reset read", waddr(5), 1'b1, 1'b0, '0, 4'h0);
    idle(1);
    bus.addr = waddr(3); bus.wdata = 32'hFFFF_FFFF; bus.byte_en = 4'hF;
    bus.ren = 1'b0; bus.wen = 1'b1;
    for (int k = 0; k < LAT - 1; k++) begin
      @(negedge clk);
      check("rstwr busy", bus.busy, 1'b1);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    check("rstwr busy at rst", bus.busy, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.wen = 1'b0;
    exp_rdata = '0;
    last_vld = 1'b0;
    @(negedge clk);
    check("rstwr busy after", bus.busy, 1'b1);
    check("rstwr rdata after", bus.rdata, 32'h0);
    @(posedge clk); #1;
    do_req("read w3", waddr(3), 1'b1, 1'b0, '0, 4'h0);
    idle(2);

    // Four-word sequential read burst
    start = cyc;
    for (int w = 0; w < 4; w++) begin
      do_req("burst", waddr(16 + w), 1'b1, 1'b0, '0, 4'h0);
      offs[w] = done_cyc - start;
    end
    check("burst off0", offs[0], 4);
    check("burst off1", offs[1], FAST ? 6 : 9);
    check("burst off2", offs[2], FAST ? 8 : 14);
    check("burst off3", offs[3], FAST ? 10 : 19);
    idle(1);

    // Randomized mix of reads, writes, both-high, sequential runs and out-of-range
    prev_a = waddr(0);
    for (int n = 0; n < 80; n++) begin
      int unsigned sel;
      int unsigned op;
      sel = $urandom_range(0, 9);
      if (sel == 0)
        a = ($urandom_range(0, 1) == 1) ? BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 7) * 4)
                                        : BASE - 32'($urandom_range(1, 4) * 4);
      else if (sel <= 3 && in_rng(prev_a) && idx(prev_a) < 31)
        a = prev_a + 32'd4;
      else
        a = waddr($urandom_range(0, 31)) + 32'($urandom_range(0, 3));
      op = $urandom_range(0, 2);
      do_req("random", a, op != 1, op != 0, $urandom, 4'($urandom_range(0, 15)));
      prev_a = a;
      if ($urandom_range(0, 9) < 3) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
